// File: rtl/queue_display_driver.sv
`default_nettype none
// ============================================================================
// queue_display_driver : 4-digit common-anode 7-segment driver for the queue
// counter (Pcount on digits 1:0, Pwait on 3:2), sequential double-dabble BCD.
// Optional feature macro: DISP_FULL_BLINK_EN            Revision: 1.0
// ============================================================================
module queue_display_driver #(
   parameter int N           = 3,
   parameter int WTIME_WIDTH = 6,
   parameter int REFRESH_DIV = 1000,
   parameter int BLINK_DIV   = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N:0]             Pcount,
   input  logic [WTIME_WIDTH:0]   Pwait,
   input  logic                   emptyFlag,
   input  logic                   fullFlag,
   output logic [6:0]             seg,
   output logic [3:0]             an,
   output logic                   dp,
   output logic                   busy
);

   localparam int         RC_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t               state;
   logic [N:0]           snap_pcount;
   logic [WTIME_WIDTH:0] snap_pwait;
   logic                 snap_empty;
   logic                 snap_full;
   logic [14:0]          pc_sr;
   logic [14:0]          pw_sr;
   logic [2:0]           step;
   logic [3:0]           pc_ones, pc_tens, pw_ones, pw_tens;
   logic                 disp_empty;
   logic                 disp_full;
   logic [RC_W-1:0]      refresh_cnt;
   logic [1:0]           digit_idx;
   logic                 refresh_wrap;
   logic                 mismatch;
   logic                 an_blank;
   logic [6:0]           seg_next;
   logic [3:0]           an_next;

   if (REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
      $error("queue_display_driver: REFRESH_DIV must be >= 2 and BLINK_DIV >= 1");
   end

   function automatic logic [6:0] clamp99(input logic [31:0] v);
      return (v > 32'd99) ? 7'd99 : v[6:0];
   endfunction

   // One double-dabble iteration on {tens, ones, binary}: add-3 correction, then shift.
   function automatic logic [14:0] dd_step(input logic [14:0] s);
      logic [14:0] a;
      a = s;
      if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
      if (a[10:7]  >= 4'd5) a[10:7]  = a[10:7]  + 4'd3;
      return {a[13:0], 1'b0};
   endfunction

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return SEG_OFF;
      endcase
   endfunction

   assign mismatch = (Pcount != snap_pcount) || (Pwait != snap_pwait) ||
                     (emptyFlag != snap_empty) || (fullFlag != snap_full);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         step        <= '0;
         pc_sr       <= '0;
         pw_sr       <= '0;
         snap_pcount <= '0;
         snap_pwait  <= '0;
         snap_empty  <= 1'b1;
         snap_full   <= 1'b0;
         pc_ones     <= '0;
         pc_tens     <= '0;
         pw_ones     <= '0;
         pw_tens     <= '0;
         disp_empty  <= 1'b1;
         disp_full   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mismatch) begin
                  snap_pcount <= Pcount;
                  snap_pwait  <= Pwait;
                  snap_empty  <= emptyFlag;
                  snap_full   <= fullFlag;
                  pc_sr       <= {8'd0, clamp99(32'(Pcount))};
                  pw_sr       <= {8'd0, clamp99(32'(Pwait))};
                  step        <= '0;
                  busy        <= 1'b1;
                  state       <= S_CONV;
               end
            end
            S_CONV: begin
               pc_sr <= dd_step(pc_sr);
               pw_sr <= dd_step(pw_sr);
               step  <= step + 3'd1;
               if (step == 3'd6) state <= S_LOAD;
            end
            S_LOAD: begin
               pc_ones    <= pc_sr[10:7];
               pc_tens    <= pc_sr[14:11];
               pw_ones    <= pw_sr[10:7];
               pw_tens    <= pw_sr[14:11];
               disp_empty <= snap_empty;
               disp_full  <= snap_full;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign refresh_wrap = (refresh_cnt == RC_W'(REFRESH_DIV - 1));
   assign an_next      = ~(4'b0001 << digit_idx);

   always_comb begin
      seg_next = SEG_OFF;
      case (digit_idx)
         2'd0:    seg_next = enc(pc_ones);
         2'd1:    seg_next = enc(pc_tens);
         2'd2:    seg_next = disp_empty ? SEG_DASH : enc(pw_ones);
         default: seg_next = disp_empty ? SEG_DASH : enc(pw_tens);
      endcase
   end

   // seg, an and dp come from the same digit index on the same edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
         seg         <= SEG_OFF;
         an          <= 4'hF;
         dp          <= 1'b1;
      end else begin
         seg <= seg_next;
         an  <= an_blank ? 4'hF : an_next;
         dp  <= ~(disp_full && (digit_idx == 2'd1));
         if (refresh_wrap) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
         end else begin
            refresh_cnt <= refresh_cnt + RC_W'(1);
         end
      end
   end

`ifdef DISP_FULL_BLINK_EN
   localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BC_W-1:0] scan_cnt;
   logic            blink;

   always_ff @(posedge clock) begin
      if (!reset || !disp_full) begin
         scan_cnt <= '0;
         blink    <= 1'b0;
      end else if (refresh_wrap && (digit_idx == 2'd3)) begin
         if (scan_cnt == BC_W'(BLINK_DIV - 1)) begin
            scan_cnt <= '0;
            blink    <= ~blink;
         end else begin
            scan_cnt <= scan_cnt + BC_W'(1);
         end
      end
   end

   assign an_blank = blink;
`else
   assign an_blank = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_display_driver.sv
`default_nettype none
// Bench for queue_display_driver: vector table + scoreboard queue, scan and busy timing checks.
module tb_queue_display_driver;

   localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                          D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                          D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                          D9 = 7'b0010000, DM = 7'b0111111;

   typedef struct {
      logic [6:0] s0, s1, s2, s3;
      logic       full;
   } exp_t;

   typedef struct {
      logic [3:0] pc;
      logic [6:0] pw;
      logic       em, fu;
      logic [6:0] s0, s1, s2, s3;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] Pcount;
   logic [6:0] Pwait;
   logic       emptyFlag, fullFlag;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp, busy;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vecs[7];

   always #5 clock = ~clock;

   queue_display_driver #(.N(3), .WTIME_WIDTH(6), .REFRESH_DIV(4), .BLINK_DIV(64)) dut (
      .clock(clock), .reset(reset), .Pcount(Pcount), .Pwait(Pwait),
      .emptyFlag(emptyFlag), .fullFlag(fullFlag),
      .seg(seg), .an(an), .dp(dp), .busy(busy)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] seg_for(input exp_t e, input int d);
      case (d)
         0:       return e.s0;
         1:       return e.s1;
         2:       return e.s2;
         default: return e.s3;
      endcase
   endfunction

   // Check one full scan (16 cycles); optionally first align to the start of digit 0.
   task automatic check_scan(input bit sync, input exp_t e, input string tag);
      int n;
      logic [3:0] ea;
      if (sync) begin
         n = 0;
         while (an == 4'b1110 && n < 40) begin tick(); n++; end
         n = 0;
         while (an != 4'b1110 && n < 40) begin tick(); n++; end
         chk({tag, "_sync_an"}, an, 4'b1110);
      end
      for (int k = 0; k < 16; k++) begin
         ea = ~(4'b0001 << (k / 4));
         chk({tag, "_an"}, an, ea);
         chk({tag, "_seg"}, seg, seg_for(e, k / 4));
         chk({tag, "_dp"}, dp, !(e.full && (k / 4) == 1));
         tick();
      end
   endtask

   task automatic drive(input logic [3:0] pc, input logic [6:0] pw, input logic em, input logic fu);
      Pcount = pc; Pwait = pw; emptyFlag = em; fullFlag = fu;
   endtask

   // Wait for busy to rise, then measure how long it stays high.
   task automatic measure_busy(output int len);
      int n;
      n = 0;
      while (!busy && n < 5) begin tick(); n++; end
      len = 0;
      while (busy && len < 30) begin tick(); len++; end
   endtask

   initial begin
      exp_t e, e_empty;
      int   len, n, total;

      e_empty = '{D0, D0, DM, DM, 1'b0};
      vecs[0] = '{4'd12, 7'd33,  1'b0, 1'b0, D2, D1, D3, D3};
      vecs[1] = '{4'd15, 7'd105, 1'b0, 1'b1, D5, D1, D9, D9};
      vecs[2] = '{4'd5,  7'd0,   1'b1, 1'b0, D5, D0, DM, DM};
      vecs[3] = '{4'd9,  7'd99,  1'b0, 1'b0, D9, D0, D9, D9};
      vecs[4] = '{4'd0,  7'd100, 1'b0, 1'b1, D0, D0, D9, D9};
      vecs[5] = '{4'd10, 7'd127, 1'b1, 1'b1, D0, D1, DM, DM};
      vecs[6] = '{4'd7,  7'd48,  1'b0, 1'b0, D7, D0, D8, D4};

      // Reset and the "--00" idle display
      reset = 1'b0;
      drive(4'd0, 7'd0, 1'b1, 1'b0);
      repeat (3) tick();
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 4'hF);
      chk("rst_dp", dp, 1'b1);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;
      tick();
      check_scan(1'b0, e_empty, "post_rst");
      chk("idle_busy", busy, 1'b0);

      // Table-driven conversions
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].pc, vecs[i].pw, vecs[i].em, vecs[i].fu);
         sb.push_back('{vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].fu});
         measure_busy(len);
         chk("busy_len", len, 8);
         e = sb.pop_front();
         check_scan(1'b1, e, "vec");
      end

      // Input changes during conversion: first value loaded, then recaptured
      drive(4'd5, 7'd20, 1'b0, 1'b0);
      sb.push_back('{D5, D0, D0, D2, 1'b0});
      sb.push_back('{D6, D0, D0, D2, 1'b0});
      tick();
      chk("busy_cap", busy, 1'b1);
      repeat (3) tick();
      Pcount = 4'd6;
      total = 0;
      n = 0;
      while (busy && n < 20) begin tick(); n++; total++; end
      chk("first_load_done", busy, 1'b0);
      tick(); total++;
      chk("busy_reassert", busy, 1'b1);
      e = sb.pop_front();
      n = 0;
      while (busy && n < 20) begin
         for (int d = 0; d < 4; d++)
            if (an == ~(4'b0001 << d)) chk("interim_05_seg", seg, seg_for(e, d));
         tick(); n++; total++;
      end
      chk("recapture_busy_len", n, 8);
      chk("recapture_within_17", total <= 17, 1'b1);
      e = sb.pop_front();
      check_scan(1'b1, e, "recap");

      // Reset in the middle of a conversion
      drive(4'd9, 7'd50, 1'b0, 1'b1);
      tick();
      chk("busy_before_abort", busy, 1'b1);
      repeat (2) tick();
      reset = 1'b0;
      drive(4'd0, 7'd0, 1'b1, 1'b0);
      tick();
      chk("abort_seg", seg, 7'h7F);
      chk("abort_an", an, 4'hF);
      chk("abort_dp", dp, 1'b1);
      chk("abort_busy", busy, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_scan(1'b0, e_empty, "abort_rel");
      chk("abort_idle_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
